hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Consumes the D-stage control bundle fields (TUseRs/TUseRt/TNew/RegWrite) emitted by the decoder.
//  Tracks every in-flight producer through E/M/W with per-stage readiness countdowns.
//  Generates the pipeline stall and the forwarding selects for the D, E and M stages.
//  Sits beside the 5-stage MIPS datapath; owns no datapath values, only register indices and timing.
// PARAMETERS
//  REG_AW    5  GPR index width
//  TIME_W    3  width of TUse/TNew/countdown fields (matches decoder TUseRs/TUseRt/TNew)
// PORTS
//  clk            in   1       pipeline clock
//  reset          in   1       asynchronous, active-high; clears all stage slots
//  D_rs, D_rt     in   REG_AW  source indices of the instruction in D
//  D_TUseRs       in   TIME_W  0=D, 1=E, 2=M, 3=never read
//  D_TUseRt       in   TIME_W  same encoding as D_TUseRs
//  D_RegWrite     in   1       D instruction writes the GRF
//  D_WA           in   REG_AW  resolved destination index (after RegDst mux)
//  D_TNew         in   TIME_W  3=ready after E (ALU/PC), 4=ready after M (load), 0=ready at once
//  stall          out  1       hold PC and the F/D register; insert a bubble into E
//  fwd_D_rs       out  2       00=GRF, 01=M-stage result, 10=W-stage result
//  fwd_D_rt       out  2       same encoding as fwd_D_rs
//  fwd_E_rs       out  2       same encoding as fwd_D_rs
//  fwd_E_rt       out  2       same encoding as fwd_D_rs
//  fwd_M_rt       out  1       1=W-stage result (sw data), 0=M-pipelined rt value
//  stall_cnt      out  32      stall-cycle count (see CONFIGURATION)
// BEHAVIOUR
//  Slots E, M, W each hold: valid, wa, rem (cycles until forwardable), rs, rt.
//  On D->E entry: rem = sat0(D_TNew - 2).
//  Slot is a producer only if valid && RegWrite && wa != 0; else wa is stored as 0.
//  Each clk edge: W<=M, M<=E, and rem decrements, saturating at 0.
//  E<=D fields when !stall. When stall, E<=bubble (valid=0, wa=0, rem=0); M/W still advance.
//  Stall (combinational): for src in {rs,rt} with src!=0 and TUse!=3:
//    any of E/M/W has wa==src && rem > TUse.
//  Forward (combinational): nearest matching producer with rem==0 wins, priority M over W.
//    A matching producer with rem>0 never selects forwarding (the stall covers it).
//  Index 0: never stalls and never forwards; selects read 00/0.
//  E-slot fwd uses stored rs/rt. fwd_M_rt uses M-slot rt vs W slot.
//  Reset (any time, mid-stall included): all slots invalid, wa=0, rem=0.
//    Outputs: stall=0, all fwd=0, stall_cnt=0.
//  Latency: stall and fwd are same-cycle functions of D inputs and slot state; no registered outputs.
// CONFIGURATION
//  HAZ_STALL_CNT_EN defined: stall_cnt increments once per clk edge with stall=1.
//    Wraps 0xFFFFFFFF->0; cleared only by reset.
//  Undefined: stall_cnt tied to 32'd0 and no counter flops are built.
// STRUCTURE
//  header.v additions: `fwd_grf 2'd0, `fwd_m 2'd1, `fwd_w 2'd2, `tuse_never 3'd3, slot field widths.
//  Sub-module hazard_slot: one stage slot (register and saturating countdown).
//    hazard_slot has inputs load/bubble/din and outputs valid/wa/rem/rs/rt.
//  hazard_ctrl_unit instantiates 3 hazard_slot instances, the compare/priority logic and the optional counter.
// TESTING
//  1. lw $1 then beq $1,$0 next (TUseRs=0) -> stall=1 for 2 cycles, then fwd_D_rs=10.
//  2. add $3 then sub $4,$3,$3 adjacent -> stall=0.
//     Next cycle fwd_E_rs=fwd_E_rt=01.
//  3. lw $5 then sw $5 (TUseRt=2) adjacent -> stall=0.
//     sw reaches M with fwd_M_rt=1.
//  4. ori $0 then add using $0 -> stall=0, all fwd=00.
//     Also: two producers of $2 in M and W -> fwd=01 (M wins).
//  5. Assert reset during a lw-beq stall -> stall=0 immediately, slots empty.
//     After release, beq sees fwd=00.
//  6. HAZ_STALL_CNT_EN defined: scenario 1 twice -> stall_cnt=4.
//     Undefined: stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared constants and types for the hazard control unit: forward-select codes,
// the never-read TUse code, the TNew bias and the default slot field widths.
package hazard_ctrl_unit_pkg;

    localparam int HCU_REG_AW    = 5;
    localparam int HCU_TIME_W    = 3;
    localparam int HCU_NUM_SLOTS = 3;

    localparam int SLOT_E = 0;
    localparam int SLOT_M = 1;
    localparam int SLOT_W = 2;

    localparam int NUM_SRCS  = 2;
    localparam int SRC_RS    = 0;
    localparam int SRC_RT    = 1;

    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_M   = 2'd1,
        FWD_W   = 2'd2
    } fwd_sel_e;

    localparam int TUSE_NEVER = 3;

    // D->E entry converts TNew (counted from D) into cycles-remaining-after-E.
    localparam int TNEW_BIAS = 2;

endpackage

// File: rtl/hazard_ctrl_unit_slot.sv
// One pipeline stage slot of the hazard tracker: holds destination, source
// indices and a saturating readiness countdown for the instruction in that stage.
module hazard_slot
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_AW      = HCU_REG_AW,
    parameter int TIME_W      = HCU_TIME_W,
    parameter bit DEC_ON_LOAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic              din_valid,
    input  logic [REG_AW-1:0] din_wa,
    input  logic [TIME_W-1:0] din_rem,
    input  logic [REG_AW-1:0] din_rs,
    input  logic [REG_AW-1:0] din_rt,
    output logic              valid,
    output logic [REG_AW-1:0] wa,
    output logic [TIME_W-1:0] rem,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt
);

    logic              valid_reg;
    logic [REG_AW-1:0] wa_reg;
    logic [TIME_W-1:0] rem_reg;
    logic [REG_AW-1:0] rs_reg;
    logic [REG_AW-1:0] rt_reg;

    logic [TIME_W-1:0] dec_src;
    logic [TIME_W-1:0] rem_next;

    // A slot fed by an older slot ages its countdown by one on the transfer;
    // the E slot loads the already-biased value straight from D.
    assign dec_src  = load ? din_rem : rem_reg;
    assign rem_next = (load && !DEC_ON_LOAD) ? din_rem :
                      ((dec_src == '0) ? '0 : dec_src - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            wa_reg    <= '0;
            rem_reg   <= '0;
            rs_reg    <= '0;
            rt_reg    <= '0;
        end else if (bubble) begin
            valid_reg <= 1'b0;
            wa_reg    <= '0;
            rem_reg   <= '0;
            rs_reg    <= '0;
            rt_reg    <= '0;
        end else if (load) begin
            valid_reg <= din_valid;
            wa_reg    <= din_valid ? din_wa : '0;
            rem_reg   <= din_valid ? rem_next : '0;
            rs_reg    <= din_valid ? din_rs : '0;
            rt_reg    <= din_valid ? din_rt : '0;
        end else begin
            rem_reg   <= rem_next;
        end
    end

    assign valid = valid_reg;
    assign wa    = wa_reg;
    assign rem   = rem_reg;
    assign rs    = rs_reg;
    assign rt    = rt_reg;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall and forwarding control for a 5-stage MIPS pipeline: tracks producers in
// E/M/W and compares them with D/E/M sources. Optional stall counter: HAZ_STALL_CNT_EN.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_AW = HCU_REG_AW,
    parameter int TIME_W = HCU_TIME_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] D_rs,
    input  logic [REG_AW-1:0] D_rt,
    input  logic [TIME_W-1:0] D_TUseRs,
    input  logic [TIME_W-1:0] D_TUseRt,
    input  logic              D_RegWrite,
    input  logic [REG_AW-1:0] D_WA,
    input  logic [TIME_W-1:0] D_TNew,
    output logic              stall,
    output logic [1:0]        fwd_D_rs,
    output logic [1:0]        fwd_D_rt,
    output logic [1:0]        fwd_E_rs,
    output logic [1:0]        fwd_E_rt,
    output logic              fwd_M_rt,
    output logic [31:0]       stall_cnt
);

    logic              slot_valid [HCU_NUM_SLOTS];
    logic [REG_AW-1:0] slot_wa    [HCU_NUM_SLOTS];
    logic [TIME_W-1:0] slot_rem   [HCU_NUM_SLOTS];
    logic [REG_AW-1:0] slot_rs    [HCU_NUM_SLOTS];
    logic [REG_AW-1:0] slot_rt    [HCU_NUM_SLOTS];

    logic              din_valid  [HCU_NUM_SLOTS];
    logic [REG_AW-1:0] din_wa     [HCU_NUM_SLOTS];
    logic [TIME_W-1:0] din_rem    [HCU_NUM_SLOTS];
    logic [REG_AW-1:0] din_rs     [HCU_NUM_SLOTS];
    logic [REG_AW-1:0] din_rt     [HCU_NUM_SLOTS];

    logic              d_producer;
    logic [TIME_W-1:0] d_rem;

    logic [REG_AW-1:0] d_src  [NUM_SRCS];
    logic [TIME_W-1:0] d_tuse [NUM_SRCS];

    // Non-producers enter with wa=0 so they can never match a source.
    assign d_producer = D_RegWrite && (D_WA != '0);
    assign d_rem      = (D_TNew > TIME_W'(TNEW_BIAS)) ? (D_TNew - TIME_W'(TNEW_BIAS)) : '0;

    assign d_src[SRC_RS]  = D_rs;
    assign d_src[SRC_RT]  = D_rt;
    assign d_tuse[SRC_RS] = D_TUseRs;
    assign d_tuse[SRC_RT] = D_TUseRt;

    for (genvar gi = 0; gi < HCU_NUM_SLOTS; gi++) begin : g_slot
        if (gi == SLOT_E) begin : g_src_d
            assign din_valid[gi] = 1'b1;
            assign din_wa[gi]    = d_producer ? D_WA  : '0;
            assign din_rem[gi]   = d_producer ? d_rem : '0;
            assign din_rs[gi]    = D_rs;
            assign din_rt[gi]    = D_rt;
        end else begin : g_src_prev
            assign din_valid[gi] = slot_valid[gi-1];
            assign din_wa[gi]    = slot_wa[gi-1];
            assign din_rem[gi]   = slot_rem[gi-1];
            assign din_rs[gi]    = slot_rs[gi-1];
            assign din_rt[gi]    = slot_rt[gi-1];
        end

        hazard_slot #(
            .REG_AW      (REG_AW),
            .TIME_W      (TIME_W),
            .DEC_ON_LOAD (gi != SLOT_E)
        ) u_slot (
            .clk       (clk),
            .rst       (reset),
            .load      (1'b1),
            .bubble    ((gi == SLOT_E) ? stall : 1'b0),
            .din_valid (din_valid[gi]),
            .din_wa    (din_wa[gi]),
            .din_rem   (din_rem[gi]),
            .din_rs    (din_rs[gi]),
            .din_rt    (din_rt[gi]),
            .valid     (slot_valid[gi]),
            .wa        (slot_wa[gi]),
            .rem       (slot_rem[gi]),
            .rs        (slot_rs[gi]),
            .rt        (slot_rt[gi])
        );
    end

    // A source stalls while any in-flight producer of it needs more cycles than
    // the consumer can wait before it must read the value.
    always_comb begin
        stall = 1'b0;
        for (int si = 0; si < NUM_SRCS; si++) begin
            if ((d_src[si] != '0) && (d_tuse[si] != TIME_W'(TUSE_NEVER))) begin
                for (int s = 0; s < HCU_NUM_SLOTS; s++) begin
                    if (slot_valid[s] && (slot_wa[s] == d_src[si]) && (slot_rem[s] > d_tuse[si])) begin
                        stall = 1'b1;
                    end
                end
            end
        end
    end

    // M wins over W; a producer whose value is not ready yet is skipped.
    function automatic fwd_sel_e pick_fwd(
        input logic [REG_AW-1:0] src,
        input logic              m_valid,
        input logic [REG_AW-1:0] m_wa,
        input logic [TIME_W-1:0] m_rem,
        input logic              w_valid,
        input logic [REG_AW-1:0] w_wa,
        input logic [TIME_W-1:0] w_rem
    );
        fwd_sel_e sel;
        sel = FWD_GRF;
        if (src != '0) begin
            if (m_valid && (m_wa == src) && (m_rem == '0)) begin
                sel = FWD_M;
            end else if (w_valid && (w_wa == src) && (w_rem == '0)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd_D_rs = pick_fwd(D_rs,
                            slot_valid[SLOT_M], slot_wa[SLOT_M], slot_rem[SLOT_M],
                            slot_valid[SLOT_W], slot_wa[SLOT_W], slot_rem[SLOT_W]);
        fwd_D_rt = pick_fwd(D_rt,
                            slot_valid[SLOT_M], slot_wa[SLOT_M], slot_rem[SLOT_M],
                            slot_valid[SLOT_W], slot_wa[SLOT_W], slot_rem[SLOT_W]);
        fwd_E_rs = pick_fwd(slot_rs[SLOT_E],
                            slot_valid[SLOT_M], slot_wa[SLOT_M], slot_rem[SLOT_M],
                            slot_valid[SLOT_W], slot_wa[SLOT_W], slot_rem[SLOT_W]);
        fwd_E_rt = pick_fwd(slot_rt[SLOT_E],
                            slot_valid[SLOT_M], slot_wa[SLOT_M], slot_rem[SLOT_M],
                            slot_valid[SLOT_W], slot_wa[SLOT_W], slot_rem[SLOT_W]);
        // Store data in M can only be refreshed from W.
        fwd_M_rt = (pick_fwd(slot_rt[SLOT_M],
                             1'b0, '0, '0,
                             slot_valid[SLOT_W], slot_wa[SLOT_W], slot_rem[SLOT_W]) == FWD_W);
    end

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (stall) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed pipeline scenarios plus random traffic,
// checked against an age/ready-time model of in-flight instructions.
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, D_WA;
    logic [2:0]  D_TUseRs, D_TUseRt, D_TNew;
    logic        D_RegWrite;
    logic        stall;
    logic [1:0]  fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
    logic        fwd_M_rt;
    logic [31:0] stall_cnt;

    hazard_ctrl_unit dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_TUseRs   (D_TUseRs),
        .D_TUseRt   (D_TUseRt),
        .D_RegWrite (D_RegWrite),
        .D_WA       (D_WA),
        .D_TNew     (D_TNew),
        .stall      (stall),
        .fwd_D_rs   (fwd_D_rs),
        .fwd_D_rt   (fwd_D_rt),
        .fwd_E_rs   (fwd_E_rs),
        .fwd_E_rt   (fwd_E_rt),
        .fwd_M_rt   (fwd_M_rt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Each issued instruction remembers the cycle it entered E; its stage is
    // its age and its value is forwardable once TNew-2-age reaches zero.
    typedef struct {
        int enter;
        int dest;
        int tnew;
        int rs;
        int rt;
    } inst_t;

    inst_t pipe_q[$];
    int    cyc     = 0;
    int    m_cnt   = 0;
    bit    m_stall = 1'b0;
    int    n_total = 0;
    int    n_bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rem_of(inst_t e);
        int r;
        r = e.tnew - 2 - (cyc - e.enter);
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit stall_of(int src, int tuse);
        if (src == 0 || tuse == 3) return 1'b0;
        foreach (pipe_q[i]) begin
            if (pipe_q[i].dest == src && rem_of(pipe_q[i]) > tuse) return 1'b1;
        end
        return 1'b0;
    endfunction

    // 1 = forward from M (age 1), 2 = forward from W (age 2), 0 = register file.
    function automatic int fwd_of(int src, int min_age);
        if (src == 0) return 0;
        for (int a = min_age; a <= 2; a++) begin
            foreach (pipe_q[i]) begin
                if ((cyc - pipe_q[i].enter) == a && pipe_q[i].dest == src && rem_of(pipe_q[i]) == 0)
                    return (a == 1) ? 1 : 2;
            end
        end
        return 0;
    endfunction

    task automatic check_all();
        int e_rs, e_rt, m_rt, exp_cnt;
        e_rs = 0; e_rt = 0; m_rt = 0;
        foreach (pipe_q[i]) begin
            if (cyc - pipe_q[i].enter == 0) begin
                e_rs = pipe_q[i].rs;
                e_rt = pipe_q[i].rt;
            end
            if (cyc - pipe_q[i].enter == 1) m_rt = pipe_q[i].rt;
        end
        m_stall = stall_of(int'(D_rs), int'(D_TUseRs)) || stall_of(int'(D_rt), int'(D_TUseRt));
`ifdef HAZ_STALL_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        chk("stall",     int'(stall),    int'(m_stall));
        chk("fwd_D_rs",  int'(fwd_D_rs), fwd_of(int'(D_rs), 1));
        chk("fwd_D_rt",  int'(fwd_D_rt), fwd_of(int'(D_rt), 1));
        chk("fwd_E_rs",  int'(fwd_E_rs), fwd_of(e_rs, 1));
        chk("fwd_E_rt",  int'(fwd_E_rt), fwd_of(e_rt, 1));
        chk("fwd_M_rt",  int'(fwd_M_rt), (fwd_of(m_rt, 2) == 2) ? 1 : 0);
        chk("stall_cnt", int'(stall_cnt), exp_cnt);
    endtask

    task automatic issue(input int rs, input int rt, input int urs, input int urt,
                         input int rw, input int wa, input int tnew);
        @(negedge clk);
        D_rs = 5'(rs); D_rt = 5'(rt);
        D_TUseRs = 3'(urs); D_TUseRt = 3'(urt);
        D_RegWrite = rw[0]; D_WA = 5'(wa); D_TNew = 3'(tnew);
        #1;
        check_all();
        $display("cyc=%0d D rs=%0d rt=%0d tu=%0d/%0d rw=%0d wa=%0d tnew=%0d | stall=%0b fD=%0d/%0d fE=%0d/%0d fM=%0b cnt=%0d",
                 cyc, rs, rt, urs, urt, rw, wa, tnew, stall, fwd_D_rs, fwd_D_rt,
                 fwd_E_rs, fwd_E_rt, fwd_M_rt, stall_cnt);
    endtask

    task automatic tick();
        inst_t e;
        @(posedge clk);
        if (m_stall) begin
            m_cnt++;
        end else begin
            e.enter = cyc + 1;
            e.dest  = (D_RegWrite && D_WA != 5'd0) ? int'(D_WA) : 0;
            e.tnew  = int'(D_TNew);
            e.rs    = int'(D_rs);
            e.rt    = int'(D_rt);
            pipe_q.push_back(e);
        end
        cyc++;
        while (pipe_q.size() > 0 && (cyc - pipe_q[0].enter) > 2) void'(pipe_q.pop_front());
    endtask

    task automatic nop();
        issue(0, 0, 3, 3, 0, 0, 0);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_stall",     int'(stall),     0);
        chk("rst_fwd_D_rs",  int'(fwd_D_rs),  0);
        chk("rst_fwd_D_rt",  int'(fwd_D_rt),  0);
        chk("rst_fwd_E_rs",  int'(fwd_E_rs),  0);
        chk("rst_fwd_E_rt",  int'(fwd_E_rt),  0);
        chk("rst_fwd_M_rt",  int'(fwd_M_rt),  0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pipe_q.delete();
        m_cnt   = 0;
        m_stall = 1'b0;
    endtask

    task automatic scen_lw_beq();
        issue(0, 1, 1, 3, 1, 1, 4);
        tick();
        issue(1, 0, 0, 0, 0, 0, 0);
        chk("lw_beq_stall1", int'(stall), 1);
        tick();
        issue(1, 0, 0, 0, 0, 0, 0);
        chk("lw_beq_stall2", int'(stall), 1);
        tick();
        issue(1, 0, 0, 0, 0, 0, 0);
        chk("lw_beq_stall3", int'(stall), 0);
        chk("lw_beq_fwd_w",  int'(fwd_D_rs), 2);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r_rs, r_rt, r_urs, r_urt, r_rw, r_wa, r_tnew, pick;
        D_rs = '0; D_rt = '0; D_TUseRs = 3'd3; D_TUseRt = 3'd3;
        D_RegWrite = 1'b0; D_WA = '0; D_TNew = '0;
        do_reset();

        scen_lw_beq();
        repeat (3) nop();

        // add $3 ; sub $4,$3,$3
        issue(0, 0, 1, 1, 1, 3, 3); tick();
        issue(3, 3, 1, 1, 1, 4, 3);
        chk("add_sub_stall", int'(stall), 0);
        tick();
        issue(0, 0, 3, 3, 0, 0, 0);
        chk("add_sub_fwd_E_rs", int'(fwd_E_rs), 1);
        chk("add_sub_fwd_E_rt", int'(fwd_E_rt), 1);
        tick();
        repeat (3) nop();

        // lw $5 ; sw $5
        issue(0, 5, 1, 3, 1, 5, 4); tick();
        issue(0, 5, 1, 2, 0, 0, 0);
        chk("lw_sw_stall", int'(stall), 0);
        tick();
        nop();
        issue(0, 0, 3, 3, 0, 0, 0);
        chk("lw_sw_fwd_M_rt", int'(fwd_M_rt), 1);
        tick();
        repeat (3) nop();

        // ori $0 ; add using $0, then two producers of $2 in M and W
        issue(0, 0, 1, 3, 1, 0, 3); tick();
        issue(0, 0, 1, 1, 1, 6, 3);
        chk("zero_stall",    int'(stall),    0);
        chk("zero_fwd_D_rs", int'(fwd_D_rs), 0);
        tick();
        issue(0, 0, 3, 3, 0, 0, 0);
        chk("zero_fwd_E_rs", int'(fwd_E_rs), 0);
        tick();
        issue(0, 0, 1, 1, 1, 2, 3); tick();
        issue(0, 0, 1, 1, 1, 2, 3); tick();
        nop();
        issue(2, 0, 1, 3, 0, 0, 0);
        chk("dup_prod_m_wins", int'(fwd_D_rs), 1);
        tick();
        repeat (3) nop();

        // reset in the middle of a load-use stall
        issue(0, 1, 1, 3, 1, 1, 4); tick();
        issue(1, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_pre_stall", int'(stall), 1);
        do_reset();
        issue(1, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_post_stall", int'(stall),    0);
        chk("mid_rst_post_fwd",   int'(fwd_D_rs), 0);
        tick();

        // random traffic; D fields are held while stalled
        r_rs = 0; r_rt = 0; r_urs = 3; r_urt = 3; r_rw = 0; r_wa = 0; r_tnew = 0;
        for (int n = 0; n < 600; n++) begin
            if (!m_stall) begin
                r_rs  = $urandom_range(0, 3);
                r_rt  = $urandom_range(0, 3);
                r_urs = $urandom_range(0, 3);
                r_urt = $urandom_range(0, 3);
                r_rw  = $urandom_range(0, 1);
                r_wa  = $urandom_range(0, 3);
                pick  = $urandom_range(0, 3);
                r_tnew = (pick == 0) ? 0 : (pick == 1) ? 3 : (pick == 2) ? 4 : $urandom_range(0, 7);
            end
            issue(r_rs, r_rt, r_urs, r_urt, r_rw, r_wa, r_tnew);
            tick();
        end

        // stall counter over two load-use scenarios
        repeat (3) nop();
        do_reset();
        scen_lw_beq();
        scen_lw_beq();
        issue(0, 0, 3, 3, 0, 0, 0);
`ifdef HAZ_STALL_CNT_EN
        chk("stall_cnt_two_scen", int'(stall_cnt), 4);
`else
        chk("stall_cnt_two_scen", int'(stall_cnt), 0);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
